unidade_controle_param: RTL and testbench

- Parametrised successor control unit for the bus-based multicycle processor.
- Integrates the step counter internally (no external Tstep or Clear) and supports a configurable register count and data width.
- Supports a configurable memory read latency (wait states) and the full 8-opcode set (mv, mvi, add, sub, ld, st, mvnz, and).
- Sits between the IR/register file/ALU datapath and the synchronous memory.
- Drives one-hot register enables plus the bus/ALU/memory strobes.

---
 rtl/unidade_controle_param.sv | 196 +++++++++++++++++++
 tb/tb_unidade_controle_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_param.sv
// rtl/unidade_controle_param.sv - multicycle processor control unit with internal step sequencing
// Fetch/execute FSM with configurable memory wait states; outputs decode state, Instrucao and GRout.
module unidade_controle_param #(
  parameter int REG_BITS = 3,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int PC_IDX   = 0,
  localparam int NREGS   = 2**REG_BITS,
  localparam int IW      = 3 + 2*REG_BITS
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [IW-1:0]     Instrucao,
  input  logic [DATA_W-1:0] GRout,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              IRin,
  output logic              ADDRin,
  output logic              DOUTin,
  output logic              W_D,
  output logic              IncrPc,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [1:0]        Ulaop,
  output logic              DINout,
  output logic              Done,
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_F_ADDR, S_F_WAIT, S_F_LOAD, S_E0, S_E1, S_E2, S_E_WAIT
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic             LAT_NZ = (MEM_LAT > 0);
  localparam logic [2:0]       LAT_M1 = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
  localparam logic [NREGS-1:0] PC_HOT = NREGS'(1) << PC_IDX;

  state_t state, state_nxt;
  logic [2:0] wait_cnt, wait_nxt;

  logic [2:0]          opcode;
  logic [REG_BITS-1:0] rx, ry;
  logic [NREGS-1:0]    rx_hot, ry_hot;

  assign opcode = Instrucao[IW-1 -: 3];
  assign rx     = Instrucao[2*REG_BITS-1 -: REG_BITS];
  assign ry     = Instrucao[REG_BITS-1:0];
  assign rx_hot = NREGS'(1) << rx;
  assign ry_hot = NREGS'(1) << ry;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    Rin       = '0;
    Rout      = '0;
    IRin      = 1'b0;
    ADDRin    = 1'b0;
    DOUTin    = 1'b0;
    W_D       = 1'b0;
    IncrPc    = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    Gout      = 1'b0;
    Ulaop     = 2'b00;
    DINout    = 1'b0;
    Done      = 1'b0;
    Busy      = (state != S_IDLE);

    case (state)
      S_IDLE: if (Run) state_nxt = S_F_ADDR;

      S_F_ADDR: begin
        Rout      = PC_HOT;
        ADDRin    = 1'b1;
        wait_nxt  = LAT_M1;
        state_nxt = LAT_NZ ? S_F_WAIT : S_F_LOAD;
      end

      S_F_WAIT: begin
        if (wait_cnt == 3'd0) state_nxt = S_F_LOAD;
        else                  wait_nxt  = wait_cnt - 3'd1;
      end

      S_F_LOAD: begin
        DINout    = 1'b1;
        IRin      = 1'b1;
        IncrPc    = 1'b1;
        state_nxt = S_E0;
      end

      S_E0: begin
        case (opcode)
          OP_MV: begin
            Rout = ry_hot;
            Rin  = rx_hot;
            Done = 1'b1;
          end
          OP_MVI, OP_LD: begin
            Rout      = (opcode == OP_MVI) ? PC_HOT : ry_hot;
            ADDRin    = 1'b1;
            wait_nxt  = LAT_M1;
            state_nxt = LAT_NZ ? S_E_WAIT : S_E1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Rout      = rx_hot;
            Ain       = 1'b1;
            state_nxt = S_E1;
          end
          OP_ST: begin
            Rout      = ry_hot;
            ADDRin    = 1'b1;
            state_nxt = S_E1;
          end
          default: begin
            // mvnz: a zero G suppresses the whole move, not just the write
            Done = 1'b1;
            if (GRout != '0) begin
              Rout = ry_hot;
              Rin  = rx_hot;
            end
          end
        endcase
      end

      S_E_WAIT: begin
        if (wait_cnt == 3'd0) state_nxt = S_E1;
        else                  wait_nxt  = wait_cnt - 3'd1;
      end

      S_E1: begin
        case (opcode)
          OP_MVI, OP_LD: begin
            DINout = 1'b1;
            Rin    = rx_hot;
            // loading the PC directly must not be disturbed by the increment
            IncrPc = (opcode == OP_MVI) && (rx != REG_BITS'(PC_IDX));
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Rout      = ry_hot;
            Gin       = 1'b1;
            Ulaop     = (opcode == OP_SUB) ? 2'b01 : (opcode == OP_AND) ? 2'b10 : 2'b00;
            state_nxt = S_E2;
          end
          OP_ST: begin
            Rout      = rx_hot;
            DOUTin    = 1'b1;
            state_nxt = S_E2;
          end
          default: state_nxt = S_IDLE;
        endcase
      end

      S_E2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            Gout = 1'b1;
            Rin  = rx_hot;
            Done = 1'b1;
          end
          OP_ST: begin
            W_D  = 1'b1;
            Done = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end

      default: state_nxt = S_IDLE;
    endcase

    if (Done) state_nxt = Run ? S_F_ADDR : S_IDLE;
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// tb/tb_unidade_controle_param.sv - directed cycle-by-cycle bench for unidade_controle_param
// Two instances: MEM_LAT=2 (dut) and MEM_LAT=0 (dut0); outputs packed into one vector per cycle.
module tb_unidade_controle_param;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run, run0;
  logic [8:0]  Instrucao;
  logic [15:0] GRout;

  logic [7:0] Rin, Rout, Rin0, Rout0;
  logic IRin, ADDRin, DOUTin, W_D, IncrPc, Ain, Gin, Gout, DINout, Done, Busy;
  logic IRin0, ADDRin0, DOUTin0, W_D0, IncrPc0, Ain0, Gin0, Gout0, DINout0, Done0, Busy0;
  logic [1:0] Ulaop, Ulaop0;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  unidade_controle_param #(.REG_BITS(3), .DATA_W(16), .MEM_LAT(2), .PC_IDX(0)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao), .GRout(GRout),
    .Rin(Rin), .Rout(Rout), .IRin(IRin), .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D),
    .IncrPc(IncrPc), .Ain(Ain), .Gin(Gin), .Gout(Gout), .Ulaop(Ulaop), .DINout(DINout),
    .Done(Done), .Busy(Busy)
  );

  unidade_controle_param #(.REG_BITS(3), .DATA_W(16), .MEM_LAT(0), .PC_IDX(0)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .Run(run0), .Instrucao(Instrucao), .GRout(GRout),
    .Rin(Rin0), .Rout(Rout0), .IRin(IRin0), .ADDRin(ADDRin0), .DOUTin(DOUTin0), .W_D(W_D0),
    .IncrPc(IncrPc0), .Ain(Ain0), .Gin(Gin0), .Gout(Gout0), .Ulaop(Ulaop0), .DINout(DINout0),
    .Done(Done0), .Busy(Busy0)
  );

  logic [28:0] obs, obs0;
  assign obs  = {Rin, Rout, IRin, ADDRin, DOUTin, W_D, IncrPc, Ain, Gin, Gout, Ulaop, DINout, Done, Busy};
  assign obs0 = {Rin0, Rout0, IRin0, ADDRin0, DOUTin0, W_D0, IncrPc0, Ain0, Gin0, Gout0, Ulaop0, DINout0, Done0, Busy0};

  localparam logic [28:0] B      = 29'(1) << 0;
  localparam logic [28:0] DONE   = 29'(1) << 1;
  localparam logic [28:0] DINO   = 29'(1) << 2;
  localparam logic [28:0] UL_SUB = 29'(1) << 3;
  localparam logic [28:0] UL_AND = 29'(2) << 3;
  localparam logic [28:0] GOUT   = 29'(1) << 5;
  localparam logic [28:0] GIN    = 29'(1) << 6;
  localparam logic [28:0] AIN    = 29'(1) << 7;
  localparam logic [28:0] INCR   = 29'(1) << 8;
  localparam logic [28:0] WD     = 29'(1) << 9;
  localparam logic [28:0] DOUTI  = 29'(1) << 10;
  localparam logic [28:0] ADDRI  = 29'(1) << 11;
  localparam logic [28:0] IRI    = 29'(1) << 12;
  localparam logic [28:0] FA     = B | ADDRI | (29'(1) << 13);
  localparam logic [28:0] FL     = B | DINO | IRI | INCR;

  function automatic logic [28:0] ro(input int r);
    return 29'(1) << (13 + r);
  endfunction

  function automatic logic [28:0] ri(input int r);
    return 29'(1) << (21 + r);
  endfunction

  task automatic test_reset;
    Resetn = 1'b0; Run = 1'b0; run0 = 1'b0; Instrucao = '0; GRout = '0;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (obs !== 29'd0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 29'd0); end
    checks++;
    if (obs0 !== 29'd0) begin errors++; $display("FAIL reset_outputs_lat0: got %h expected %h", obs0, 29'd0); end
    Resetn = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if (obs !== 29'd0) begin errors++; $display("FAIL idle_no_run: got %h expected %h", obs, 29'd0); end
  endtask

  task automatic test_mv;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | DONE | ri(3) | ro(5), 29'd0};
    Instrucao = 9'b000_011_101; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL mv cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_mvi;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | ADDRI | ro(0), B, B, B | DINO | ri(2) | INCR | DONE, 29'd0};
    Instrucao = 9'b001_010_000; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL mvi cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_alu;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | ro(1) | AIN, B | ro(4) | GIN | UL_SUB, B | GOUT | ri(1) | DONE, 29'd0};
    Instrucao = 9'b011_001_100; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL sub cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
    ex = '{FA, B, B, FL, B | ro(2) | AIN, B | ro(3) | GIN | UL_AND, B | GOUT | ri(2) | DONE, 29'd0};
    Instrucao = 9'b111_010_011; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL and cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_mvnz;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | DONE, 29'd0};
    Instrucao = 9'b110_110_111; GRout = 16'h0000; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL mvnz_zero cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
    ex = '{FA, B, B, FL, B | DONE | ri(6) | ro(7), 29'd0};
    GRout = 16'h0001; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL mvnz_nonzero cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
    GRout = 16'h0000;
  endtask

  task automatic test_back_to_back;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | ro(3) | ADDRI, B | ro(2) | DOUTI, B | WD | DONE,
           FA, B, B, FL, B | ro(3) | ADDRI, B | ro(2) | DOUTI, B | WD | DONE, 29'd0};
    Instrucao = 9'b101_010_011; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      if (i == 7) Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL st_b2b cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_ld;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | ro(1) | ADDRI, B, B, B | DINO | ri(5) | DONE, 29'd0};
    Instrucao = 9'b100_101_001; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL ld cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_zero_latency;
    logic [28:0] ex [$];
    ex = '{FA, FL, B | ro(1) | ADDRI, B | DINO | ri(5) | DONE, 29'd0};
    Instrucao = 9'b100_101_001; run0 = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      run0 = 1'b0;
      checks++;
      if (obs0 !== ex[i]) begin errors++; $display("FAIL ld_lat0 cycle %0d: got %h expected %h", i, obs0, ex[i]); end
    end
    ex = '{FA, FL, B | ro(0) | ADDRI, B | DINO | ri(0) | DONE, 29'd0};
    Instrucao = 9'b001_000_011; run0 = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      run0 = 1'b0;
      checks++;
      if (obs0 !== ex[i]) begin errors++; $display("FAIL mvi_pc_lat0 cycle %0d: got %h expected %h", i, obs0, ex[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [28:0] ex [$];
    ex = '{FA, B, B, FL, B | ro(1) | AIN, B | ro(2) | GIN};
    Instrucao = 9'b010_001_010; Run = 1'b1;
    foreach (ex[i]) begin
      @(posedge Clock); #1;
      Run = 1'b0;
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL add_pre_reset cycle %0d: got %h expected %h", i, obs, ex[i]); end
    end
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (obs !== 29'd0) begin errors++; $display("FAIL async_reset_outputs: got %h expected %h", obs, 29'd0); end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== 29'd0) begin errors++; $display("FAIL idle_after_reset cycle %0d: got %h expected %h", i, obs, 29'd0); end
    end
  endtask

  initial begin
    test_reset;
    test_mv;
    test_mvi;
    test_alu;
    test_mvnz;
    test_back_to_back;
    test_ld;
    test_zero_latency;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
